// File: rtl/dbg_bus_bridge_pkg.sv
// Shared constants for the byte-stream debug bus bridge: command/response
// codes, FSM encodings and the response record handed to the tx shifter.
package dbg_bus_bridge_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;
  localparam logic [7:0] RSP_TMO = 8'h54;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_BUS  = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  localparam int RSP_MAX = 5;

  typedef struct packed {
    logic [8*RSP_MAX-1:0] bytes;
    logic [2:0]           len;
  } rsp_t;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WR) || (b == CMD_RD);
  endfunction

endpackage

// File: rtl/dbg_bus_bridge_if.sv
// UART byte streams and SoC memory bus seen by the debug bridge.
interface dbg_bus_bridge_if #(
  parameter int ADDR_BYTES = 4
) ();
  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic                    rx_ready;
  logic [7:0]              tx_data;
  logic                    tx_valid;
  logic                    tx_ready;
  logic                    stb;
  logic                    ack;
  logic                    we;
  logic [8*ADDR_BYTES-1:0] addr;
  logic [31:0]             dtw;
  logic [31:0]             dtr;

  modport master (
    input  rx_data, rx_valid, tx_ready, ack, dtr,
    output rx_ready, tx_data, tx_valid, stb, we, addr, dtw
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, ack, dtr,
    input  rx_ready, tx_data, tx_valid, stb, we, addr, dtw
  );
endinterface

// File: rtl/dbg_resp_shifter.sv
// Holds up to RSP_MAX response bytes and plays them out MSB first over a
// valid/ready handshake; o_done flags acceptance of the final byte.
module dbg_resp_shifter
  import dbg_bus_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  rsp_t       i_rsp,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_done
);

  logic [8*RSP_MAX-1:0] r_buf;
  logic [2:0]           r_cnt;
  logic                 w_fire;

  assign o_valid = (r_cnt != 3'd0);
  assign w_fire  = o_valid && i_ready;
  assign o_done  = w_fire && (r_cnt == 3'd1);
  assign o_data  = r_buf[8*RSP_MAX-1 -: 8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buf <= '0;
      r_cnt <= 3'd0;
    end else if (i_load) begin
      r_buf <= i_rsp.bytes;
      r_cnt <= i_rsp.len;
    end else if (w_fire) begin
      r_buf <= {r_buf[8*RSP_MAX-9:0], 8'h00};
      r_cnt <= r_cnt - 3'd1;
    end
  end

endmodule

// File: rtl/dbg_bus_bridge.sv
// Debug bus initiator: parses framed command bytes, runs one bus read or
// write with a bounded wait for ack, and streams back the response bytes.
module dbg_bus_bridge
  import dbg_bus_bridge_pkg::*;
#(
  parameter int ADDR_BYTES = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              reset,
  dbg_bus_bridge_if.master  bus,
  output logic              busy
);

  localparam int AW    = 8 * ADDR_BYTES;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int CNT_W = $clog2(((ADDR_BYTES > 4) ? ADDR_BYTES : 4) + 1);

  logic [2:0]       r_state;
  logic             r_rx_rdy;
  logic             r_we;
  logic [AW-1:0]    r_addr;
  logic [31:0]      r_dtw;
  logic [CNT_W-1:0] r_cnt;
  logic [TMO_W-1:0] r_tmo;

  logic [2:0]       w_nxt;
  logic             w_rx_fire;
  logic             w_ack;
  logic             w_tmo;
  logic             w_addr_last;
  logic             w_data_last;
  logic             w_load;
  logic             w_tx_done;
  rsp_t             w_rsp;

  assign w_rx_fire   = bus.rx_valid && r_rx_rdy;
  assign w_ack       = (r_state == ST_BUS) && bus.ack;
  // ack takes priority over an expiring timeout in the same cycle
  assign w_tmo       = (r_state == ST_BUS) && !bus.ack && (r_tmo == TMO_W'(TIMEOUT));
  assign w_addr_last = (r_cnt == CNT_W'(ADDR_BYTES - 1));
  assign w_data_last = (r_cnt == CNT_W'(3));
  assign w_load      = (w_nxt == ST_RESP) && (r_state != ST_RESP);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_rx_fire) w_nxt = is_cmd(bus.rx_data) ? ST_ADDR : ST_RESP;
      ST_ADDR: if (w_rx_fire && w_addr_last) w_nxt = r_we ? ST_DATA : ST_BUS;
      ST_DATA: if (w_rx_fire && w_data_last) w_nxt = ST_BUS;
      ST_BUS:  if (w_ack || w_tmo) w_nxt = ST_RESP;
      ST_RESP: if (w_tx_done) w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rsp.bytes = {RSP_ERR, 32'h0};
    w_rsp.len   = 3'd1;
    if (w_tmo) begin
      w_rsp.bytes = {RSP_TMO, 32'h0};
    end else if (w_ack) begin
      if (r_we) begin
        w_rsp.bytes = {RSP_OK, 32'h0};
      end else begin
        w_rsp.bytes = {CMD_RD, bus.dtr};
        w_rsp.len   = 3'd5;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_rx_rdy <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_dtw    <= '0;
      r_cnt    <= '0;
      r_tmo    <= '0;
    end else begin
      r_state  <= w_nxt;
      r_rx_rdy <= (w_nxt == ST_IDLE) || (w_nxt == ST_ADDR) || (w_nxt == ST_DATA);
      case (r_state)
        ST_IDLE: if (w_rx_fire) begin
          r_cnt <= '0;
          if (is_cmd(bus.rx_data)) r_we <= (bus.rx_data == CMD_WR);
        end
        ST_ADDR: if (w_rx_fire) begin
          r_addr <= AW'({r_addr, bus.rx_data});
          r_cnt  <= w_addr_last ? '0 : r_cnt + 1'b1;
        end
        ST_DATA: if (w_rx_fire) begin
          r_dtw <= {r_dtw[23:0], bus.rx_data};
          r_cnt <= w_data_last ? '0 : r_cnt + 1'b1;
        end
        ST_BUS: r_tmo <= (bus.ack || w_tmo) ? '0 : r_tmo + 1'b1;
        default: ;
      endcase
    end
  end

  dbg_resp_shifter u_resp (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_rsp   (w_rsp),
    .i_ready (bus.tx_ready),
    .o_data  (bus.tx_data),
    .o_valid (bus.tx_valid),
    .o_done  (w_tx_done)
  );

  assign bus.rx_ready = r_rx_rdy;
  assign bus.stb      = (r_state == ST_BUS);
  assign bus.we       = r_we;
  assign bus.addr     = r_addr;
  assign bus.dtw      = r_dtw;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dbg_bus_bridge.sv
// Bench for dbg_bus_bridge: directed scenarios plus randomized command mix
// checked against a memory-level model of the command protocol.
module tb_dbg_bus_bridge;

  localparam int AB  = 4;
  localparam int TMO = 7;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  dbg_bus_bridge_if #(.ADDR_BYTES(AB)) bus ();

  dbg_bus_bridge #(.ADDR_BYTES(AB), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit ack_en = 1'b1;
  bit ack_force = 1'b0;
  int ack_delay = 0;
  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] exp_mem [logic [31:0]];
  int cur_len = 0, last_len = 0, pulses = 0, unstable = 0;
  logic cap_we;
  logic [31:0] cap_addr, cap_dtw;

  bit tx_hold = 1'b0, tx_rand = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Protocol-level model: memory map plus expected response byte stream.
  function automatic void model_cmd(input logic [7:0] c, input logic [31:0] a,
                                    input logic [31:0] d, input bit tmo);
    logic [31:0] w;
    if (c == 8'h57 || c == 8'h52) begin
      if (tmo) exp_q.push_back(8'h54);
      else if (c == 8'h57) begin
        exp_mem[a] = d;
        exp_q.push_back(8'h4B);
      end else begin
        w = exp_mem.exists(a) ? exp_mem[a] : dflt(a);
        exp_q.push_back(8'h52);
        for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
      end
    end else begin
      exp_q.push_back(8'h3F);
    end
  endfunction

  // Bus responder and strobe monitor
  initial begin
    bus.ack = 1'b0;
    bus.dtr = '0;
    forever begin
      @(negedge clk);
      bus.ack = ack_force;
      bus.dtr = $urandom;
      if (bus.stb === 1'b1) begin
        if (cur_len == 0) begin
          cap_we = bus.we; cap_addr = bus.addr; cap_dtw = bus.dtw;
        end else if (bus.we !== cap_we || bus.addr !== cap_addr || bus.dtw !== cap_dtw) begin
          unstable++;
        end
        if (ack_en && cur_len == ack_delay) begin
          bus.ack = 1'b1;
          if (bus.we) bus_mem[bus.addr] = bus.dtw;
          else bus.dtr = bus_mem.exists(bus.addr) ? bus_mem[bus.addr] : dflt(bus.addr);
        end
        cur_len++;
      end else if (cur_len > 0) begin
        last_len = cur_len;
        pulses++;
        cur_len = 0;
      end
    end
  end

  // Transmit sink: byte is counted when valid&&ready holds into the next edge
  initial begin
    bus.tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_ready = !tx_hold && (!tx_rand || $urandom_range(0, 3) != 0);
      if (bus.tx_valid === 1'b1 && bus.tx_ready) got_q.push_back(bus.tx_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL rx_accept byte %h not taken, rx_ready %b required 1", b, bus.rx_ready);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
    send_byte(c);
    if (c == 8'h57 || c == 8'h52)
      for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
    if (c == 8'h57)
      for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
  endtask

  task automatic wait_resp(input int n);
    int t = 0;
    while (got_q.size() < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      checks++; errors++;
      $display("FAIL resp_timeout got %0d bytes required %0d", got_q.size(), n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (bus.stb !== 1'b0) begin errors++; $display("FAIL reset_stb got %b required 0", bus.stb); end
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL reset_we got %b required 0", bus.we); end
    checks++; if (bus.addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h required 0", bus.addr); end
    checks++; if (bus.dtw !== 32'h0) begin errors++; $display("FAIL reset_dtw got %h required 0", bus.dtw); end
    checks++; if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin
      errors++; $display("FAIL reset_tx got valid %b data %h required 0/00", bus.tx_valid, bus.tx_data); end
    checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got %b required 0", bus.rx_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL post_reset_rx_ready got %b required 1", bus.rx_ready); end
  endtask

  task automatic test_write();
    int p0 = pulses;
    got_q.delete(); exp_q.delete();
    ack_delay = 2;
    send_cmd(8'h57, 32'h0000_1004, 32'hDEAD_BEEF);
    model_cmd(8'h57, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0);
    wait_resp(exp_q.size());
    checks++; if (pulses - p0 != 1 || last_len != 3) begin
      errors++; $display("FAIL write_stb got %0d pulses len %0d required 1 pulse len 3", pulses - p0, last_len); end
    checks++; if (cap_we !== 1'b1 || cap_addr !== 32'h0000_1004 || cap_dtw !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL write_bus got we %b addr %h dtw %h required 1 00001004 deadbeef", cap_we, cap_addr, cap_dtw); end
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL write_rsp_len got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL write_rsp[%0d] got %h required %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy got %b required 0", busy); end
  endtask

  task automatic test_read();
    int p0 = pulses;
    got_q.delete(); exp_q.delete();
    bus_mem[32'h8] = 32'h1234_5678;
    exp_mem[32'h8] = 32'h1234_5678;
    ack_delay = 0;
    send_cmd(8'h52, 32'h0000_0008, 32'h0);
    model_cmd(8'h52, 32'h0000_0008, 32'h0, 1'b0);
    wait_resp(exp_q.size());
    checks++; if (pulses - p0 != 1 || last_len != 1 || cap_we !== 1'b0 || cap_addr !== 32'h8) begin
      errors++; $display("FAIL read_stb got %0d pulses len %0d we %b addr %h required 1 1 0 00000008",
                         pulses - p0, last_len, cap_we, cap_addr); end
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL read_rsp_len got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL read_rsp[%0d] got %h required %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]); end
    end
  endtask

  task automatic test_bad_cmd();
    int p0 = pulses;
    got_q.delete(); exp_q.delete();
    send_byte(8'hA5);
    model_cmd(8'hA5, 32'h0, 32'h0, 1'b0);
    wait_resp(exp_q.size());
    checks++; if (pulses != p0) begin errors++; $display("FAIL bad_stb got %0d pulses required 0", pulses - p0); end
    checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL bad_rsp got %0d bytes first %h required 1 byte %h", got_q.size(),
                         (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q[0]); end
    got_q.delete(); exp_q.delete();
    ack_delay = 1;
    send_cmd(8'h52, 32'h0000_0008, 32'h0);
    model_cmd(8'h52, 32'h0000_0008, 32'h0, 1'b0);
    wait_resp(exp_q.size());
    checks++; if (last_len != 2) begin errors++; $display("FAIL bad_then_read_len got %0d required 2", last_len); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bad_then_read[%0d] got %h required %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]); end
    end
  endtask

  task automatic test_timeout();
    int p0;
    got_q.delete(); exp_q.delete();
    ack_en = 1'b0;
    send_cmd(8'h52, 32'h0000_0020, 32'h0);
    model_cmd(8'h52, 32'h0000_0020, 32'h0, 1'b1);
    wait_resp(exp_q.size());
    ack_en = 1'b1;
    checks++; if (last_len != TMO + 1) begin errors++; $display("FAIL tmo_stb_len got %0d required %0d", last_len, TMO + 1); end
    checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL tmo_rsp got %0d bytes first %h required 1 byte %h", got_q.size(),
                         (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q[0]); end
    p0 = pulses;
    ack_force = 1'b1;
    repeat (5) @(negedge clk);
    ack_force = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (pulses != p0 || busy !== 1'b0 || got_q.size() != 1) begin
      errors++; $display("FAIL late_ack got pulses %0d busy %b bytes %0d required 0 0 1", pulses - p0, busy, got_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [7:0] d0;
    int t = 0;
    got_q.delete(); exp_q.delete();
    tx_hold = 1'b1;
    ack_delay = 1;
    send_cmd(8'h52, 32'h0000_0040, 32'h0);
    model_cmd(8'h52, 32'h0000_0040, 32'h0, 1'b0);
    bus.rx_data  = 8'hA5;
    bus.rx_valid = 1'b1;
    while (bus.tx_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    d0 = bus.tx_data;
    checks++; if (d0 !== exp_q[0]) begin errors++; $display("FAIL bp_first got %h required %h", d0, exp_q[0]); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (bus.rx_ready !== 1'b0 || bus.tx_valid !== 1'b1 || bus.tx_data !== d0) begin
        errors++; $display("FAIL bp_stall[%0d] got rx_ready %b tx_valid %b tx_data %h required 0 1 %h",
                           i, bus.rx_ready, bus.tx_valid, bus.tx_data, d0); end
    end
    tx_hold = 1'b0;
    send_byte(8'hA5);
    model_cmd(8'hA5, 32'h0, 32'h0, 1'b0);
    wait_resp(exp_q.size());
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_rsp_len got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_rsp[%0d] got %h required %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]); end
    end
  endtask

  task automatic test_async_reset();
    int p0;
    got_q.delete(); exp_q.delete();
    ack_en = 1'b0;
    send_cmd(8'h57, 32'h0000_0300, 32'hCAFE_F00D);
    @(negedge clk);
    checks++; if (bus.stb !== 1'b1) begin errors++; $display("FAIL ar_stb_before got %b required 1", bus.stb); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.stb !== 1'b0 || busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
      errors++; $display("FAIL ar_async got stb %b busy %b tx_valid %b required 0 0 0", bus.stb, busy, bus.tx_valid); end
    @(negedge clk);
    reset = 1'b1;
    ack_en = 1'b1;
    ack_delay = 1;
    repeat (2) @(negedge clk);
    p0 = pulses;
    send_cmd(8'h57, 32'h0000_0300, 32'h0BAD_F00D);
    model_cmd(8'h57, 32'h0000_0300, 32'h0BAD_F00D, 1'b0);
    send_cmd(8'h52, 32'h0000_0300, 32'h0);
    model_cmd(8'h52, 32'h0000_0300, 32'h0, 1'b0);
    wait_resp(exp_q.size());
    checks++; if (pulses - p0 != 2) begin errors++; $display("FAIL ar_pulses got %0d required 2", pulses - p0); end
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL ar_rsp_len got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ar_rsp[%0d] got %h required %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] c;
    logic [31:0] a, d;
    bit tmo;
    int p0, k, want_len;
    tx_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9);
      a = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      d = $urandom;
      c = ($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52;
      if (k == 0) begin
        c = 8'($urandom);
        if (c == 8'h57 || c == 8'h52) c = 8'hFF;
      end
      tmo = (k == 1);
      ack_en = !tmo;
      ack_delay = $urandom_range(0, 3);
      want_len = tmo ? TMO + 1 : ack_delay + 1;
      got_q.delete(); exp_q.delete();
      p0 = pulses;
      send_cmd(c, a, d);
      model_cmd(c, a, d, tmo);
      wait_resp(exp_q.size());
      ack_en = 1'b1;
      checks++; if (got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rnd%0d_rsp_len got %0d required %0d", n, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rnd%0d_rsp[%0d] got %h required %h", n, i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]); end
      end
      if (k == 0) begin
        checks++; if (pulses != p0) begin errors++; $display("FAIL rnd%0d_bad_stb got %0d pulses required 0", n, pulses - p0); end
      end else begin
        checks++; if (pulses - p0 != 1 || last_len != want_len || cap_addr !== a || cap_we !== (c == 8'h57)) begin
          errors++; $display("FAIL rnd%0d_bus got pulses %0d len %0d addr %h we %b required 1 %0d %h %b",
                             n, pulses - p0, last_len, cap_addr, cap_we, want_len, a, (c == 8'h57)); end
        if (c == 8'h57) begin
          checks++; if (cap_dtw !== d) begin errors++; $display("FAIL rnd%0d_dtw got %h required %h", n, cap_dtw, d); end
        end
      end
    end
    tx_rand = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_cmd();
    test_timeout();
    test_backpressure();
    test_async_reset();
    test_random();
    checks++; if (unstable != 0) begin errors++; $display("FAIL bus_stable got %0d changes required 0", unstable); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbg_bus_bridge.md
Name: dbg_bus_bridge

Overview:
- Bus initiator driven by a byte stream. It receives framed command bytes from a UART core's receive side, executes single-word reads/writes on the SoC memory bus (stb/ack/we/addr/dtw/dtr), and returns response bytes on the transmit side.
- Sits between the UART byte interface and the bus arbiter. It is the host-side counterpart of the bus responders, used for debug poke/peek and program loading.

Parameters:
- ADDR_BYTES, 4, number of address bytes per command; the bus address is 8*ADDR_BYTES bits wide.
- TIMEOUT, 1023, maximum cycles stb is held waiting for ack before the transaction is abandoned. Must be ≥1. Counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  bridge accepts rx byte this cycle
- tx_data  out  8  response byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART transmitter accepts tx byte
- stb  out  1  bus strobe
- ack  in  1  bus acknowledge
- we  out  1  bus write enable
- addr  out  8*ADDR_BYTES  bus address
- dtw  out  32  bus write data
- dtr  in  32  bus read data, valid when ack=1
- busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE; stb=0, we=0, addr=0, dtw=0, tx_valid=0, tx_data=0, rx_ready=0, busy=0; byte counter, timeout counter and data register cleared.
- rx handshake: a byte transfers on the clk edge with rx_valid&&rx_ready. rx_ready=1 only in IDLE, ADDR and DATA.
- tx handshake: a byte transfers with tx_valid&&tx_ready. tx_data/tx_valid stay stable until accepted.
- Protocol, all multi-byte fields MSB first:
  - Write: 0x57, ADDR_BYTES address bytes, 4 data bytes. Response: 0x4B.
  - Read: 0x52, ADDR_BYTES address bytes. Response: 0x52, then 4 data bytes dtr[31:24]..dtr[7:0].
  - Any other command byte: respond 0x3F, return to IDLE.
  - Bus timeout: respond 0x54 in place of the normal response.
- FSM states:
  - IDLE: accept command byte; latch we (1 for 0x57, 0 for 0x52); go ADDR, or RESP with 0x3F for an unknown command.
  - ADDR: shift each byte into addr (addr <= {addr[..-8], byte}); after ADDR_BYTES bytes go DATA (write) or BUS (read).
  - DATA: shift 4 bytes into dtw; after the 4th go BUS.
  - BUS: stb=1 from the first BUS cycle; addr/we/dtw stable while stb=1.
    - On ack=1: that same edge drops stb, latches dtr (read), clears the timeout counter, goes RESP.
    - Minimum latency: ack present in the first BUS cycle gives a 1-cycle strobe.
    - Timeout counter increments each BUS cycle without ack. At count==TIMEOUT with no ack, stb drops and the state goes RESP with 0x54.
    - ack and timeout in the same cycle: ack wins.
  - RESP: present response bytes in order. Byte count is 1 for write, error or timeout; 5 for a read. After the last accepted byte go IDLE.
- ack while stb=0 is ignored. rx bytes arriving outside IDLE/ADDR/DATA are back-pressured, not dropped.
- Reset asserted mid-transaction: stb and tx_valid drop immediately (asynchronous). Partial command discarded.
- dtw is not cleared after a write; addr holds its last value between commands.

Decomposition:
- Shared package/include: command constants CMD_WR=8'h57, CMD_RD=8'h52; response constants RSP_OK=8'h4B, RSP_ERR=8'h3F, RSP_TMO=8'h54; FSM state encodings.
- Optional sub-module dbg_resp_shifter: loads up to 5 bytes plus a count and drives the tx valid/ready handshake. Single module is also acceptable.

Test Plan:
- Write: rx 57 00 00 10 04 DE AD BE EF, responder ack after 2 cycles -> one stb pulse of 3 cycles with we=1, addr=0x00001004, dtw=0xDEADBEEF; tx 4B; busy low afterwards.
- Read: rx 52 00 00 00 08, responder returns dtr=0x12345678 with ack in the first strobe cycle -> stb exactly 1 cycle, we=0; tx 52 12 34 56 78.
- Bad command: rx 0xA5 -> no stb; tx 3F; next valid read then completes normally.
- Timeout (TIMEOUT=7): read with ack tied 0 -> stb high exactly 8 cycles then low; tx 54; a late ack afterwards is ignored.
- Back-pressure: tx_ready low 10 cycles during a read response and rx_valid held high -> tx_data stable, rx_ready=0 throughout, no bytes lost or duplicated.
- Async reset mid-BUS: pull reset low while stb=1 -> stb=0 and busy=0 without waiting for clk; after release, a full write completes correctly.
